// File: rtl/conv_test_source.sv
// Purpose : test-pattern source; PRBS-15 bits -> rate-1/2 K=7 convolutional encoder -> bit0 error injector.
// Latency : i_vld to o_prs_vld 1 cycle, to o_enc_vld 2 cycles, to o_vld 3 cycles; one word per cycle.
// Backpressure: none; every valid input produces one valid output and the source never stalls.
//
// Ports:
//   clk, reset_n              - clock (rising edge) and asynchronous active-low reset
//   i_vld                     - request one new PRBS symbol this cycle
//   i_enable                  - error injection enable
//   i_first_err, i_err_rate   - index of first corrupted word, spacing between errors (0 = single error)
//   o_prs_vld, o_prs_sym      - PRBS stage output
//   o_enc_vld, o_enc_word     - encoder stage output (bit1 = G1 branch, bit0 = G2 branch)
//   o_vld, o_word             - final output after error injection
module conv_test_source #(
  parameter logic [14:0] PRS_SEED = 15'h7FFF,
  parameter logic [6:0]  G1       = 7'o171,
  parameter logic [6:0]  G2       = 7'o133
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_vld,
  input  logic        i_enable,
  input  logic [10:0] i_first_err,
  input  logic [10:0] i_err_rate,
  output logic        o_prs_vld,
  output logic        o_prs_sym,
  output logic        o_enc_vld,
  output logic [1:0]  o_enc_word,
  output logic        o_vld,
  output logic [1:0]  o_word
);

  // ---------------------------------------------------------------- PRBS
  logic [14:0] prs_state;
  logic        prs_fb;

  assign prs_fb = prs_state[14] ^ prs_state[13];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prs_state <= PRS_SEED;
      o_prs_vld <= 1'b0;
      o_prs_sym <= 1'b0;
    end else begin
      o_prs_vld <= i_vld;
      if (i_vld) begin
        prs_state <= {prs_state[13:0], prs_fb};
        o_prs_sym <= prs_fb;
      end
    end
  end

  // ------------------------------------------------------------- encoder
  // enc_hist[5] is the most recent past input bit; the current symbol
  // sits above it so the generator MSB taps the bit being encoded.
  logic [5:0] enc_hist;
  logic [6:0] enc_vec;

  assign enc_vec = {o_prs_sym, enc_hist};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_hist   <= 6'd0;
      o_enc_vld  <= 1'b0;
      o_enc_word <= 2'b00;
    end else begin
      o_enc_vld <= o_prs_vld;
      if (o_prs_vld) begin
        o_enc_word <= {^(enc_vec & G1), ^(enc_vec & G2)};
        enc_hist   <= enc_vec[6:1];
      end
    end
  end

  // ------------------------------------------------------- error injector
  // word_cnt counts encoder words whether or not injection is enabled, so
  // the error positions are tied to the word index, not to enable timing.
  // hit_seen suppresses repeat hits when the spacing is zero (one-shot mode),
  // including after word_cnt wraps back around to the target.
  logic [10:0] word_cnt;
  logic [10:0] err_tgt;
  logic        hit_seen;
  logic        err_hit;

  assign err_hit = o_enc_vld && i_enable && (word_cnt == err_tgt) &&
                   !((i_err_rate == 11'd0) && hit_seen);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= 11'd0;
      // Target follows the live first-error index while reset is held.
      err_tgt  <= i_first_err;
      hit_seen <= 1'b0;
      o_vld    <= 1'b0;
      o_word   <= 2'b00;
    end else begin
      o_vld  <= o_enc_vld;
      o_word <= o_enc_word ^ {1'b0, err_hit};
      if (o_enc_vld) begin
        word_cnt <= word_cnt + 11'd1;
      end
      if (err_hit) begin
        err_tgt  <= err_tgt + i_err_rate;
        hit_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_test_source.sv
module tb_conv_test_source;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_vld = 1'b0;
  logic        i_enable = 1'b0;
  logic [10:0] i_first_err = 11'd0;
  logic [10:0] i_err_rate = 11'd0;
  logic        o_prs_vld, o_prs_sym, o_enc_vld, o_vld;
  logic [1:0]  o_enc_word, o_word;

  always #5 clk = ~clk;

  conv_test_source dut (
    .clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_enable(i_enable),
    .i_first_err(i_first_err), .i_err_rate(i_err_rate),
    .o_prs_vld(o_prs_vld), .o_prs_sym(o_prs_sym),
    .o_enc_vld(o_enc_vld), .o_enc_word(o_enc_word),
    .o_vld(o_vld), .o_word(o_word)
  );

  typedef struct { int idx; bit prs; bit [1:0] enc; } vec_t;
  typedef struct { bit en; int first; int rate; int n; } cfg_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit       prs_q[$];
  bit [1:0] enc_q[$];
  bit [1:0] out_q[$];
  int       out_cyc_q[$];
  int       drv_q[$];
  bit       m_prs[$];
  bit [1:0] m_enc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_prs_vld) prs_q.push_back(o_prs_sym);
    if (o_enc_vld) enc_q.push_back(o_enc_word);
    if (o_vld) begin
      out_q.push_back(o_word);
      out_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference PRBS + encoder built directly from the polynomial definitions.
  function automatic void build_model(int n);
    logic [14:0] s = 15'h7FFF;
    logic [5:0]  h = 6'd0;
    logic        f;
    logic [6:0]  v;
    m_prs.delete();
    m_enc.delete();
    for (int i = 0; i < n; i++) begin
      f = s[14] ^ s[13];
      s = {s[13:0], f};
      v = {f, h};
      m_prs.push_back(f);
      m_enc.push_back({^(v & 7'o171), ^(v & 7'o133)});
      h = v[6:1];
    end
  endfunction

  // Absolute word w is corrupted iff it lies on first + k*rate (spacing < 2048,
  // so the 11-bit wrap of counter and target never causes an early match).
  function automatic bit is_hit(int w, bit en, int first, int rate);
    if (!en) return 1'b0;
    if (rate == 0) return (w == first);
    return (w >= first) && (((w - first) % rate) == 0);
  endfunction

  task automatic clear_q();
    prs_q.delete(); enc_q.delete(); out_q.delete();
    out_cyc_q.delete(); drv_q.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    i_vld = 1'b0;
    repeat (2) @(negedge clk);
    clear_q();
    reset_n = 1'b1;
  endtask

  task automatic run_cont(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_vld = 1'b1;
      drv_q.push_back(cyc);
    end
    @(negedge clk);
    i_vld = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_stream(string tag, int n, bit en, int first, int rate);
    int pm, em, om, lm;
    bit [1:0] exp_w;
    pm = 0; em = 0; om = 0; lm = 0;
    chk({tag, "_out_count"}, out_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i >= prs_q.size() || prs_q[i] !== m_prs[i]) pm++;
      if (i >= enc_q.size() || enc_q[i] !== m_enc[i]) em++;
      exp_w = m_enc[i] ^ {1'b0, is_hit(i, en, first, rate)};
      if (i >= out_q.size() || out_q[i] !== exp_w) begin
        if (om == 0 && i < out_q.size())
          $display("  %s first bad word %0d: got %0d want %0d", tag, i, out_q[i], exp_w);
        om++;
      end
      if (i >= out_cyc_q.size() || i >= drv_q.size() || out_cyc_q[i] != drv_q[i] + 3) lm++;
    end
    chk({tag, "_prs_mismatches"}, pm, 0);
    chk({tag, "_enc_mismatches"}, em, 0);
    chk({tag, "_out_mismatches"}, om, 0);
    chk({tag, "_latency_mismatches"}, lm, 0);
  endtask

  vec_t tbl[24];
  cfg_t cfgs[5];

  initial begin
    int ones, per;
    bit [1:0] tmp;

    // Hand-derived start of the stream from seed 7FFF: 14 zeros, then 1.
    for (int i = 0; i < 14; i++) tbl[i] = '{i, 1'b0, 2'b00};
    tbl[14] = '{14, 1'b1, 2'b11};
    tbl[15] = '{15, 1'b0, 2'b10};
    tbl[16] = '{16, 1'b0, 2'b11};
    tbl[17] = '{17, 1'b0, 2'b11};
    tbl[18] = '{18, 1'b0, 2'b00};
    tbl[19] = '{19, 1'b0, 2'b01};
    tbl[20] = '{20, 1'b0, 2'b11};
    tbl[21] = '{21, 1'b0, 2'b00};
    tbl[22] = '{28, 1'b1, 2'b11};
    tbl[23] = '{29, 1'b1, 2'b01};

    cfgs[0] = '{1'b1, 4,    30, 2200};
    cfgs[1] = '{1'b1, 4,    0,  2100};
    cfgs[2] = '{1'b1, 0,    1,  40};
    cfgs[3] = '{1'b1, 2047, 5,  2100};
    cfgs[4] = '{1'b0, 4,    30, 100};

    build_model(32800);

    // Reset state
    #2 reset_n = 1'b0;
    #3 chk("reset_outputs", {o_prs_vld, o_prs_sym, o_enc_vld, o_enc_word, o_vld, o_word}, 0);
    reset_dut();
    repeat (3) @(negedge clk);
    chk("idle_no_valids", {o_prs_vld, o_enc_vld, o_vld}, 0);

    // Continuous run, injection off, full PRBS period
    i_enable = 1'b0;
    run_cont(32800);
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("tbl_prs_%0d", tbl[k].idx),
          (tbl[k].idx < prs_q.size()) ? 32'(prs_q[tbl[k].idx]) : 32'hFFFF, tbl[k].prs);
      chk($sformatf("tbl_enc_%0d", tbl[k].idx),
          (tbl[k].idx < enc_q.size()) ? 32'(enc_q[tbl[k].idx]) : 32'hFFFF, tbl[k].enc);
    end
    ones = 0; per = 0;
    for (int i = 0; i < 32767 && i < prs_q.size(); i++) ones += prs_q[i];
    for (int i = 0; i < 33; i++)
      if (i + 32767 >= prs_q.size() || prs_q[i] !== prs_q[i + 32767]) per++;
    chk("prs_ones_per_period", ones, 16384);
    chk("prs_period_repeat", per, 0);
    check_stream("cont", 32800, 1'b0, 0, 0);

    // Error-injection configurations
    for (int c = 0; c < 5; c++) begin
      i_enable    = cfgs[c].en;
      i_first_err = 11'(cfgs[c].first);
      i_err_rate  = 11'(cfgs[c].rate);
      reset_dut();
      run_cont(cfgs[c].n);
      check_stream($sformatf("cfg%0d", c), cfgs[c].n, cfgs[c].en, cfgs[c].first, cfgs[c].rate);
      if (cfgs[c].en) begin
        tmp = (cfgs[c].first < out_q.size()) ? out_q[cfgs[c].first] : 2'b00;
        chk($sformatf("cfg%0d_first_err_word", c), tmp, m_enc[cfgs[c].first] ^ 2'b01);
      end
    end

    // Sparse valids: one request every 64 cycles
    i_enable = 1'b0;
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      i_vld = 1'b1;
      drv_q.push_back(cyc);
      @(negedge clk);
      i_vld = 1'b0;
      repeat (62) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_stream("sparse", 20, 1'b0, 0, 0);

    // Mid-stream asynchronous reset with one-shot injection active
    i_enable = 1'b1;
    i_first_err = 11'd4;
    i_err_rate = 11'd0;
    reset_dut();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      i_vld = 1'b1;
      drv_q.push_back(cyc);
    end
    tmp = (out_q.size() > 4) ? out_q[4] : 2'b00;
    chk("midrst_pre_word4", tmp, 2'b01);
    #2 reset_n = 1'b0;
    #1 chk("midrst_outputs_cleared",
           {o_prs_vld, o_prs_sym, o_enc_vld, o_enc_word, o_vld, o_word}, 0);
    i_vld = 1'b0;
    @(negedge clk);
    clear_q();
    @(negedge clk);
    reset_n = 1'b1;
    run_cont(40);
    check_stream("midrst_post", 40, 1'b1, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
